y86_pipe_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage Y86-64 pipeline (F/D/E/M/W).

---
 rtl/y86_pkg.sv | 21 ++
 rtl/y86_pipe_ctrl_if.sv | 38 +++
 rtl/sat_counter.sv | 33 +++
 rtl/y86_pipe_ctrl.sv | 109 ++++++++++
 tb/tb_y86_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 pipeline controller: icodes, status codes,
// the "no register" id and the run-state enum.
package y86_pkg;

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHalted} state_e;

  // Instructions whose destination is written from memory in the M stage.
  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/y86_pipe_ctrl_if.sv
// Pipeline <-> controller signal bundle. master = pipeline side, slave = controller.
interface y86_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_Cnd;
  logic [3:0]       M_icode;
  logic [2:0]       m_stat;
  logic [2:0]       W_stat;
  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc_en;
  logic             halted;
  logic [2:0]       stat_out;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted,
           stat_out, cycle_cnt, stall_cnt
  );

  modport slave (
    input  start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted,
           stat_out, cycle_cnt, stall_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with async reset and synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_n,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!clr_n) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/y86_pipe_ctrl.sv
// Y86-64 pipeline hazard controller: stall/bubble generation, run-state FSM
// and cycle/stall performance counters.
module y86_pipe_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic            clk,
  input logic            rst_n,
  y86_pipe_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic       halted_q, halted_d;
  logic [2:0] stat_q, stat_d;
  logic       active, lu, mis, rt, stall_en, clr_n;

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StRun;
      StRun:    if (bus.m_stat != S_AOK) state_d = StDrain;
      StDrain: begin
        if (bus.W_stat != S_AOK) begin
          state_d = StHalted;
          stat_d  = bus.W_stat;
        end
      end
      StHalted: state_d = StHalted;
    endcase
    halted_d = (state_d == StHalted);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      halted_q <= 1'b0;
      stat_q   <= S_AOK;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      stat_q   <= stat_d;
    end
  end

  assign active = (state_q == StRun) || (state_q == StDrain);

  // Hazard equations; zero-latency from the current pipeline register contents.
  always_comb begin
    lu  = is_load(bus.E_icode) && (bus.E_dstM != RNONE) &&
          ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    mis = (bus.E_icode == I_JXX) && !bus.e_Cnd;
    rt  = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
    bus.F_stall   = 1'b0;
    bus.D_stall   = 1'b0;
    bus.D_bubble  = 1'b0;
    bus.E_bubble  = 1'b0;
    bus.M_bubble  = 1'b0;
    bus.W_stall   = 1'b0;
    bus.set_cc_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.F_stall  = 1'b1;
        bus.D_bubble = 1'b1;
        bus.E_bubble = 1'b1;
        bus.M_bubble = 1'b1;
      end
      StHalted: begin
        bus.F_stall = 1'b1;
        bus.D_stall = 1'b1;
        bus.W_stall = 1'b1;
      end
      StRun, StDrain: begin
        bus.F_stall   = lu | rt;
        bus.D_stall   = lu;
        bus.D_bubble  = mis | (rt & ~lu);
        bus.E_bubble  = mis | lu;
        bus.M_bubble  = (bus.m_stat != S_AOK) | (bus.W_stat != S_AOK);
        bus.W_stall   = (bus.W_stat != S_AOK);
        bus.set_cc_en = (bus.E_icode == I_OPQ) && (bus.m_stat == S_AOK) &&
                        (bus.W_stat == S_AOK);
      end
    endcase
  end

  assign bus.halted   = halted_q;
  assign bus.stat_out = stat_q;
  assign stall_en     = active & bus.F_stall;
  // A fresh run always starts counting from zero.
  assign clr_n        = !((state_q == StIdle) && bus.start);

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (active),
    .clr_n (clr_n),
    .cnt   (bus.cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .clr_n (clr_n),
    .cnt   (bus.stall_cnt)
  );

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Self-checking bench for y86_pipe_ctrl: behavioural model checked every cycle
// plus hand-computed directed expectations.
module tb_y86_pipe_ctrl;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam int MS_IDLE = 0, MS_RUN = 1, MS_DRAIN = 2, MS_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  y86_pipe_ctrl_if #(.CNT_W(CW)) bus ();

  y86_pipe_ctrl #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: run state, latched status and counters as plain integers.
  int m_state = MS_IDLE;
  int m_stat  = 1;
  int m_cyc   = 0;
  int m_stl   = 0;

  // Controls packed as {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en}.
  function automatic logic [6:0] exp_ctrl(input int st);
    logic ld, mp, rr, f, ds, db, eb, mb, ws, cc;
    if (st == MS_IDLE) return 7'b1011100;
    if (st == MS_HALT) return 7'b1100010;
    ld = (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_dstM != 4'hF &&
         (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
    mp = bus.E_icode == 4'h7 && bus.e_Cnd == 1'b0;
    rr = bus.D_icode == 4'h9 || bus.E_icode == 4'h9 || bus.M_icode == 4'h9;
    f  = ld || rr;
    ds = ld;
    db = ld ? mp : (mp || rr);
    eb = mp || ld;
    mb = bus.m_stat != 3'd1 || bus.W_stat != 3'd1;
    ws = bus.W_stat != 3'd1;
    cc = bus.E_icode == 4'h6 && !mb;
    return {f, ds, db, eb, mb, ws, cc};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = MS_IDLE;
      m_stat  = 1;
      m_cyc   = 0;
      m_stl   = 0;
    end else begin
      if (m_state == MS_RUN || m_state == MS_DRAIN) begin
        if (m_cyc < CMAX) m_cyc++;
        if (exp_ctrl(m_state)[6] && m_stl < CMAX) m_stl++;
      end
      case (m_state)
        MS_IDLE:  if (bus.start) m_state = MS_RUN;
        MS_RUN:   if (bus.m_stat != 3'd1) m_state = MS_DRAIN;
        MS_DRAIN: if (bus.W_stat != 3'd1) begin
          m_state = MS_HALT;
          m_stat  = int'(bus.W_stat);
        end
        default:  m_state = m_state;
      endcase
    end
  end

  function automatic logic [6:0] dut_ctrl();
    return {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble, bus.M_bubble,
            bus.W_stall, bus.set_cc_en};
  endfunction

  always @(negedge clk) begin
    chk("model_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(m_state)));
    chk("model_status", {28'd0, bus.halted, bus.stat_out},
        {28'd0, (m_state == MS_HALT), 3'(m_stat)});
    chk("model_cycle_cnt", 32'(bus.cycle_cnt), 32'(m_cyc));
    chk("model_stall_cnt", 32'(bus.stall_cnt), 32'(m_stl));
  end

  task automatic idle_in();
    bus.start   = 1'b0;
    bus.D_icode = 4'h1;
    bus.d_srcA  = 4'hF;
    bus.d_srcB  = 4'hF;
    bus.E_icode = 4'h1;
    bus.E_dstM  = 4'hF;
    bus.e_Cnd   = 1'b0;
    bus.M_icode = 4'h1;
    bus.m_stat  = 3'd1;
    bus.W_stat  = 3'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'(dut_ctrl()), 32'h5C);
    chk("rst_status", {28'd0, bus.halted, bus.stat_out}, 32'h1);
    chk("rst_cycle_cnt", 32'(bus.cycle_cnt), 32'h0);
    step();
    rst_n = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("pre_start_ctrl", 32'(dut_ctrl()), 32'h5C);
    step();
    bus.start = 1'b0;                                   // cycle A: RUN, nops
    @(negedge clk);
    chk("run_ctrl", 32'(dut_ctrl()), 32'h00);
    step();
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;   // B: load-use
    @(negedge clk);
    chk("loaduse", 32'(dut_ctrl()), 32'h68);
    step();
    idle_in();                                          // C
    @(negedge clk);
    chk("loaduse_one_cycle", 32'(dut_ctrl()), 32'h00);
    step();
    bus.E_icode = 4'h7; bus.e_Cnd = 1'b0;               // D: mispredict
    @(negedge clk);
    chk("mispredict", 32'(dut_ctrl()), 32'h18);
    step();
    idle_in(); bus.D_icode = 4'h9;                      // E: ret in D
    @(negedge clk);
    chk("misp_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    chk("misp_cycle_cnt", 32'(bus.cycle_cnt), 32'd4);
    chk("ret_D", 32'(dut_ctrl()), 32'h50);
    step();
    idle_in(); bus.E_icode = 4'h9;                      // F
    @(negedge clk);
    chk("ret_E", 32'(dut_ctrl()), 32'h50);
    step();
    idle_in(); bus.M_icode = 4'h9;                      // G
    @(negedge clk);
    chk("ret_M", 32'(dut_ctrl()), 32'h50);
    step();
    idle_in(); bus.D_icode = 4'h9; bus.E_icode = 4'hB;  // H: popq load-use beats ret
    bus.E_dstM = 4'h2; bus.d_srcB = 4'h2;
    @(negedge clk);
    chk("ret_stall_cnt", 32'(bus.stall_cnt), 32'd4);
    chk("lu_over_ret", 32'(dut_ctrl()), 32'h68);
    step();
    idle_in(); bus.D_icode = 4'h9; bus.E_icode = 4'h7;  // I: ret behind mispredict
    @(negedge clk);
    chk("misp_and_ret", 32'(dut_ctrl()), 32'h58);
    step();
    idle_in(); bus.E_icode = 4'h6;                      // J: opq sets cc
    @(negedge clk);
    chk("opq_set_cc", 32'(dut_ctrl()), 32'h01);
    step();
    bus.m_stat = 3'd4;                                  // L: halt reaches M
    @(negedge clk);
    chk("pre_halt_cycle_cnt", 32'(bus.cycle_cnt), 32'd10);
    chk("pre_halt_stall_cnt", 32'(bus.stall_cnt), 32'd6);
    chk("halt_in_M", 32'(dut_ctrl()), 32'h04);
    step();
    bus.m_stat = 3'd1; bus.W_stat = 3'd4;               // M: DRAIN, halt in W
    @(negedge clk);
    chk("halt_in_W", 32'(dut_ctrl()), 32'h06);
    step();
    idle_in();                                          // N: HALTED
    @(negedge clk);
    chk("halted_status", {28'd0, bus.halted, bus.stat_out}, 32'hC);
    chk("halted_ctrl", 32'(dut_ctrl()), 32'h62);
    chk("halted_cycle_cnt", 32'(bus.cycle_cnt), 32'd12);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_ignored", {28'd0, bus.halted, bus.stat_out}, 32'hC);
    chk("halted_cnt_hold", 32'(bus.cycle_cnt), 32'd12);

    // Saturation, then async reset while draining.
    step();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.D_icode = 4'h9;
    repeat (20) step();
    @(negedge clk);
    chk("sat_cycle_cnt", 32'(bus.cycle_cnt), 32'd15);
    chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'd15);
    step();
    idle_in(); bus.m_stat = 3'd2;
    step();
    bus.m_stat = 3'd1;
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("drain_rst_ctrl", 32'(dut_ctrl()), 32'h5C);
    chk("drain_rst_status", {28'd0, bus.halted, bus.stat_out}, 32'h1);
    chk("drain_rst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    chk("drain_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
